// File: rtl/uart_host_cmd_tx.sv
// uart_host_cmd_tx: host-side UART command transmitter with a small byte FIFO
//   Optional parity stage: define UART_HOST_PARITY_EN to include it.
//   UART_CLK    clock, all logic on its rising edge
//   RST         synchronous active-low reset (flushes FIFO, FSM to IDLE)
//   CMD_DATA    byte to enqueue
//   CMD_VALID   enqueue request
//   CMD_READY   queue can accept this cycle
//   PRESCALE    UART_CLK cycles per bit (values below 2 act as 2)
//   PAR_TYP     0 even, 1 odd parity (ignored without UART_HOST_PARITY_EN)
//   GAP_BITS    idle bit-times inserted after each stop bit
//   TX_OUT      registered serial line, idles high
//   BUSY        frame or trailing gap in progress
//   FRAME_DONE  one-cycle pulse on the last stop-bit cycle
//   FIFO_LEVEL  number of queued bytes
module uart_host_cmd_tx #(
   parameter int DATA_WIDTH     = 8,
   parameter int FIFO_DEPTH     = 4,
   parameter int PRESCALE_WIDTH = 6
) (
   input  logic                        UART_CLK,
   input  logic                        RST,
   input  logic [DATA_WIDTH-1:0]       CMD_DATA,
   input  logic                        CMD_VALID,
   output logic                        CMD_READY,
   input  logic [PRESCALE_WIDTH-1:0]   PRESCALE,
   input  logic                        PAR_TYP,
   input  logic [3:0]                  GAP_BITS,
   output logic                        TX_OUT,
   output logic                        BUSY,
   output logic                        FRAME_DONE,
   output logic [$clog2(FIFO_DEPTH):0] FIFO_LEVEL
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int BW = ($clog2(DATA_WIDTH) > 4) ? $clog2(DATA_WIDTH) : 4;
`ifdef UART_HOST_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_GAP} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_GAP} state_t;
`endif
   state_t                    r_state;
   logic [DATA_WIDTH-1:0]     r_mem [FIFO_DEPTH];
   logic [AW-1:0]             r_wr, r_rd;
   logic [AW:0]               r_level;
   logic [DATA_WIDTH-1:0]     r_shift;
   logic [PRESCALE_WIDTH-1:0] r_p, r_cnt;
   logic [3:0]                r_gap;
   logic [BW-1:0]             r_bit;
   logic                      r_tx, r_busy, r_done;
   logic                      w_push, w_pop, w_last, w_line;
`ifdef UART_HOST_PARITY_EN
   logic                      r_par;
`else
   logic                      w_unused_par;
   assign w_unused_par = PAR_TYP;
`endif
   assign CMD_READY  = r_level != (AW+1)'(FIFO_DEPTH);
   assign w_push     = CMD_VALID & CMD_READY;
   assign w_pop      = (r_state == S_IDLE) && (r_level != '0);
   assign w_last     = r_cnt == r_p - PRESCALE_WIDTH'(1);
   assign TX_OUT     = r_tx;
   assign BUSY       = r_busy;
   assign FRAME_DONE = r_done;
   assign FIFO_LEVEL = r_level;
   always_comb begin
      w_line = 1'b1;
      if (r_state == S_START) w_line = 1'b0;
      else if (r_state == S_DATA) w_line = r_shift[0];
`ifdef UART_HOST_PARITY_EN
      else if (r_state == S_PARITY) w_line = r_par;
`endif
   end
   always_ff @(posedge UART_CLK) begin
      if (w_push) r_mem[r_wr] <= CMD_DATA;
   end
   always_ff @(posedge UART_CLK) begin
      if (!RST) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_level <= '0;
      end else begin
         if (w_push) r_wr <= r_wr + AW'(1);
         if (w_pop) r_rd <= r_rd + AW'(1);
         r_level <= r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
      end
   end
   // Outputs are registered from the current state, so the line trails the FSM by one cycle;
   // the IDLE pop cycle thus becomes the single idle-high cycle between back-to-back frames.
   always_ff @(posedge UART_CLK) begin
      if (!RST) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_bit   <= '0;
         r_p     <= PRESCALE_WIDTH'(2);
         r_gap   <= '0;
         r_tx    <= 1'b1;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_tx   <= w_line;
         r_busy <= r_state != S_IDLE;
         r_done <= (r_state == S_STOP) && w_last;
         r_cnt  <= (r_state == S_IDLE || w_last) ? '0 : r_cnt + PRESCALE_WIDTH'(1);
         case (r_state)
            S_IDLE: if (w_pop) begin
               r_shift <= r_mem[r_rd];
               r_p     <= (PRESCALE < PRESCALE_WIDTH'(2)) ? PRESCALE_WIDTH'(2) : PRESCALE;
               r_gap   <= GAP_BITS;
`ifdef UART_HOST_PARITY_EN
               r_par   <= ^r_mem[r_rd] ^ PAR_TYP;
`endif
               r_state <= S_START;
            end
            S_START: if (w_last) begin
               r_bit   <= '0;
               r_state <= S_DATA;
            end
            S_DATA: if (w_last) begin
               r_shift <= r_shift >> 1;
               r_bit   <= r_bit + BW'(1);
`ifdef UART_HOST_PARITY_EN
               if (r_bit == BW'(DATA_WIDTH - 1)) r_state <= S_PARITY;
`else
               if (r_bit == BW'(DATA_WIDTH - 1)) r_state <= S_STOP;
`endif
            end
`ifdef UART_HOST_PARITY_EN
            S_PARITY: if (w_last) r_state <= S_STOP;
`endif
            S_STOP: if (w_last) begin
               r_bit   <= '0;
               r_state <= (r_gap != 4'd0) ? S_GAP : S_IDLE;
            end
            S_GAP: if (w_last) begin
               r_bit <= r_bit + BW'(1);
               if (r_bit == BW'(r_gap - 4'd1)) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_host_cmd_tx.sv
// tb_uart_host_cmd_tx: scoreboard bench decoding TX_OUT frames against queued bytes
module tb_uart_host_cmd_tx;
   localparam int DW = 8;
`ifdef UART_HOST_PARITY_EN
   localparam int NB = DW + 3;
`else
   localparam int NB = DW + 2;
`endif
   typedef struct {
      logic [7:0] b;
      int         n;
   } item_t;
   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] cmd_data;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [5:0] prescale;
   logic       par_typ;
   logic [3:0] gap_bits;
   logic       tx_out;
   logic       busy;
   logic       frame_done;
   logic [2:0] fifo_level;
   item_t      exp_q[$];
   int         cyc = 0, n_tot = 0, n_pass = 0, idle_bad = 0;
   int         last_end = -100000, last_gap = 0, last_p = 2;
   bit         abort = 1'b1, mon_busy = 1'b0;
   logic [10:0] h_cur, h_prev;
   uart_host_cmd_tx dut (
      .UART_CLK(clk), .RST(rst), .CMD_DATA(cmd_data), .CMD_VALID(cmd_valid),
      .CMD_READY(cmd_ready), .PRESCALE(prescale), .PAR_TYP(par_typ), .GAP_BITS(gap_bits),
      .TX_OUT(tx_out), .BUSY(busy), .FRAME_DONE(frame_done), .FIFO_LEVEL(fifo_level)
   );
   always #5 clk = ~clk;
   // cyc = index of the latest rising edge; h_prev = config seen at the edge before it
   always @(posedge clk) begin
      cyc++;
      h_prev = h_cur;
      h_cur  = {prescale, par_typ, gap_bits};
   end
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_tot++;
      if (act === req) n_pass++;
      else $display("FAIL %s: actual %0h required %0h", nm, act, req);
   endtask
   task automatic fail(input string nm, input int v);
      n_tot++;
      $display("FAIL %s: actual %0d cycles required completion", nm, v);
   endtask
   task automatic push(input logic [7:0] b, output int acc);
      int t = 0;
      cmd_data  = b;
      cmd_valid = 1'b1;
      while (cmd_ready !== 1'b1 && t < 20000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 20000) fail("push_timeout", t);
      acc = cyc + 1;
      exp_q.push_back('{b: b, n: acc});
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask
   task automatic drain(input int lim);
      int t = 0;
      while ((exp_q.size() != 0 || mon_busy || busy) && t < lim) begin
         @(negedge clk);
         t++;
      end
      if (t >= lim) fail("drain_timeout", t);
   endtask
   task automatic wait_fall();
      int t = 0;
      while (tx_out !== 1'b0 && t < 2000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 2000) fail("start_timeout", t);
   endtask
   // Monitor: frame start is due one cycle after the byte is in the FIFO and the line
   // has finished the previous frame plus its gap, plus the pop cycle.
   initial begin : mon
      int s, p, es;
      logic [10:0] cf;
      logic [15:0] bits;
      bit st, bz, dn;
      item_t e;
      logic v;
      forever begin
         @(negedge clk);
         if (abort) continue;
         if (tx_out !== 1'b0) begin
            if (frame_done !== 1'b0) idle_bad++;
            continue;
         end
         mon_busy = 1'b1;
         s  = cyc;
         cf = h_prev;
         p  = (cf[10:5] < 6'd2) ? 2 : int'(cf[10:5]);
         if (exp_q.size() == 0) begin
            fail("unexpected_frame", s);
            e.b = 8'h00;
            e.n = s - 2;
         end else e = exp_q.pop_front();
         es = (e.n > last_end + last_gap * last_p) ? e.n + 2 : last_end + last_gap * last_p + 2;
         st = 1'b1; bz = 1'b1; dn = 1'b1; bits = '0;
         for (int k = 0; k < NB * p; k++) begin
            if (k != 0) @(negedge clk);
            if (abort) break;
            v = tx_out;
            if (k % p == 0) bits[k / p] = v;
            else if (v !== bits[k / p]) st = 1'b0;
            if (busy !== 1'b1) bz = 1'b0;
            if (frame_done !== (k == NB * p - 1)) dn = 1'b0;
         end
         if (!abort) begin
            chk("start_time", s, es);
            chk("start_bit", bits[0], 0);
            chk("data", bits[DW:1], e.b);
`ifdef UART_HOST_PARITY_EN
            chk("parity", bits[DW+1], ^e.b ^ cf[4]);
`endif
            chk("stop_bit", bits[NB-1], 1);
            chk("bit_stable", st, 1);
            chk("busy_in_frame", bz, 1);
            chk("frame_done", dn, 1);
            last_end = cyc;
            last_gap = int'(cf[3:0]);
            last_p   = p;
         end
         mon_busy = 1'b0;
      end
   end
   initial begin : watchdog
      #900000;
      $display("FAIL watchdog: actual timeout required $finish");
      $fatal(1, "watchdog");
   end
   initial begin : main
      int a, a0, s, bad;
      cmd_data = '0; cmd_valid = 1'b0; prescale = 6'd8; par_typ = 1'b0; gap_bits = 4'd0; rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_tx", tx_out, 1);
      chk("reset_busy", busy, 0);
      chk("reset_done", frame_done, 0);
      chk("reset_level", fifo_level, 0);
      chk("reset_ready", cmd_ready, 1);
      rst = 1'b1;
      abort = 1'b0;
      @(negedge clk);
      par_typ = 1'b1;
      push(8'hAA, a);
      drain(2000);
      par_typ = 1'b0;
      push(8'hAA, a0);
      push(8'h05, a);
      push(8'hEA, a);
      push(8'hBB, a);
      push(8'h05, a);
      chk("burst_level", fifo_level, 4);
      chk("burst_ready", cmd_ready, 0);
      push(8'h11, a);
      chk("hold_accept", a, a0 + NB * 8 + 3);
      drain(5000);
      push(8'hEA, a);
      drain(2000);
      par_typ = 1'b1;
      push(8'hEA, a);
      drain(2000);
      par_typ = 1'b0;
      gap_bits = 4'd3;
      push(8'hCC, a);
      push(8'hDD, a);
      wait_fall();
      repeat (20) @(negedge clk);
      prescale = 6'd16;
      drain(5000);
      prescale = 6'd8;
      gap_bits = 4'd0;
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            prescale = 6'($urandom_range(0, 12));
            par_typ  = 1'($urandom_range(0, 1));
            gap_bits = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
         end
         push(8'($urandom_range(0, 255)), a);
         if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 40)) @(negedge clk);
      end
      drain(40000);
      prescale = 6'd8; par_typ = 1'b0; gap_bits = 4'd0;
      repeat (2) @(negedge clk);
      push(8'h3C, a);
      push(8'h5A, a);
      push(8'h96, a);
      wait_fall();
      s = cyc;
      while (cyc < s + 28) @(negedge clk);
      abort = 1'b1;
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_tx", tx_out, 1);
      chk("midrst_level", fifo_level, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_ready", cmd_ready, 1);
      chk("midrst_done", frame_done, 0);
      rst = 1'b1;
      exp_q.delete();
      last_end = -100000;
      bad = 0;
      repeat (200) begin
         @(negedge clk);
         if (tx_out !== 1'b1 || busy !== 1'b0) bad++;
      end
      chk("no_frame_after_reset", bad, 0);
      chk("idle_frame_done", idle_bad, 0);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule

// File: doc/uart_host_cmd_tx.md
# uart_host_cmd_tx

Host-side UART command transmitter that sits directly upstream of the system's `RX_IN` pin. It serialises command bytes into UART frames at a programmable bit period. Typical traffic is write (0xAA), read (0xBB), ALU-with-operands (0xCC) and ALU-without-operands (0xDD) command sequences. Bytes are queued in a small internal FIFO, so a host or bench can push a whole command burst and let the block pace it onto the line.

## Interface
Parameters:
- `DATA_WIDTH`, 8 — bits per frame payload.
- `FIFO_DEPTH`, 4 — command queue depth; must be a power of 2, ≥2.
- `PRESCALE_WIDTH`, 6 — width of the `PRESCALE` input.

Ports:
- `UART_CLK`  in  1  — single clock; all logic on its rising edge.
- `RST`  in  1  — reset, synchronous, active-low.
- `CMD_DATA`  in  DATA_WIDTH  — byte to enqueue.
- `CMD_VALID`  in  1  — enqueue request.
- `CMD_READY`  out  1  — queue can accept this cycle.
- `PRESCALE`  in  PRESCALE_WIDTH  — `UART_CLK` cycles per bit.
- `PAR_TYP`  in  1  — parity type: 0 = even, 1 = odd.
- `GAP_BITS`  in  4  — idle bit-times inserted after each stop bit.
- `TX_OUT`  out  1  — serial line; idles high.
- `BUSY`  out  1  — a frame or its trailing gap is in progress.
- `FRAME_DONE`  out  1  — one-cycle pulse at the end of the stop bit.
- `FIFO_LEVEL`  out  clog2(FIFO_DEPTH)+1  — number of queued bytes.

## Operation
- **Enqueue**
  - A byte is enqueued when `CMD_VALID & CMD_READY` on a rising edge.
  - `CMD_READY = (FIFO_LEVEL != FIFO_DEPTH)`.
  - A push while full is refused, even if a pop occurs in the same cycle.
  - A simultaneous push and pop leaves the level unchanged.
- **FSM states:** IDLE, START, DATA, PARITY (present only with the macro), STOP, GAP.
- **IDLE**
  - `TX_OUT`=1 and `BUSY`=0.
  - If the FIFO is non-empty: pop the head into the shift register and latch `PRESCALE`, `PAR_TYP` and `GAP_BITS`, then go to START.
  - Latched values stay fixed for the whole frame; input changes mid-frame take effect on the next frame.
- **Bit timer**
  - Counts 0 to P-1, where P is the latched `PRESCALE`.
  - P < 2 is treated as 2.
  - Each state lasts exactly P cycles per bit.
- **START:** `TX_OUT`=0 for 1 bit, then DATA.
- **DATA:** `DATA_WIDTH` bits, LSB first; after the last bit go to PARITY, or to STOP when parity is compiled out.
- **PARITY:** one bit, equal to the XOR of the data bits, inverted when `PAR_TYP`=1.
- **STOP**
  - `TX_OUT`=1 for 1 bit.
  - `FRAME_DONE` pulses on its last cycle.
  - Next state is GAP if latched `GAP_BITS` ≠ 0, else IDLE.
- **GAP:** `TX_OUT`=1 for `GAP_BITS`×P cycles, then IDLE.
- **`BUSY`:** high in every state except IDLE.
- **Reset** (`RST`=0 at an edge), also mid-frame:
  - FIFO is flushed and the FSM returns to IDLE.
  - Outputs after that edge: `TX_OUT`=1, `BUSY`=0, `FRAME_DONE`=0, `FIFO_LEVEL`=0, `CMD_READY`=1.

## Timing
- **Output registering:** `TX_OUT` is registered, with no combinational path from any input.
- **Start latency:** a byte accepted at edge N into an empty FIFO while IDLE produces the `TX_OUT` falling edge at edge N+2 (pop at N+1, registered start bit at N+2).
- **Frame length:** (1 + `DATA_WIDTH` + Pb + 1)×P cycles, where Pb = 1 with parity and 0 without. Default, parity on, P=8: 88 cycles.
- **Back-to-back frames:** with `GAP_BITS`=0 and the FIFO non-empty, exactly one idle-high cycle (the IDLE pop cycle) separates the stop bit from the next start bit.
- **Level update:** `FIFO_LEVEL` updates on the edge after a push or pop.

## Configuration
- Macro: `UART_HOST_PARITY_EN`.
  - **Defined:** PARITY state present; 11-bit frames for 8-bit data; `PAR_TYP` is used.
  - **Undefined:** PARITY state and parity logic removed; 10-bit frames; `PAR_TYP` is ignored (left unconnected internally).

## Test plan
All scenarios use P=8 unless stated.
1. **Single frame, odd parity:** `UART_HOST_PARITY_EN` defined, `PAR_TYP`=1, `GAP_BITS`=0, push 0xAA.
   - `TX_OUT` per 8-cycle bit: 0,0,1,0,1,0,1,0,1,1,1.
   - `FRAME_DONE` pulses at cycle 88 of the frame; `BUSY` high for 88 cycles.
2. **Command burst:** push 0xAA, 0x05, 0xEA, 0xBB, 0x05 on consecutive cycles.
   - All five are accepted; `FIFO_LEVEL` reaches 4.
   - A 6th push is held with `CMD_READY`=0 until the second frame starts.
   - Frames appear in push order, each separated by exactly 1 idle cycle.
3. **Parity types:** push 0xEA with `PAR_TYP`=0, then 0xEA with `PAR_TYP`=1; parity bits are 1 and 0 respectively.
4. **Gap and prescale latching:** `GAP_BITS`=3, push 0xCC, 0xDD.
   - The second start bit begins 24+1 cycles after the first stop ends.
   - Changing `PRESCALE` to 16 mid-frame leaves that frame at 8 cycles per bit; the next frame uses 16.
5. **Reset mid-frame:** `RST`=0 during the 3rd data bit with 2 bytes queued.
   - Next edge: `TX_OUT`=1, `FIFO_LEVEL`=0, `BUSY`=0.
   - No frame follows after `RST`=1.
6. **Parity compiled out:** `UART_HOST_PARITY_EN` undefined, push 0x05.
   - `TX_OUT`: 0,1,0,1,0,0,0,0,0,1.
   - Frame lasts 80 cycles.
